// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data-memory responder with RISC-V B/H/W access modes.
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset (RAM contents are kept)
//   req_valid  : request present          req_ready : responder idle, can accept
//   req_we     : 1 store, 0 load          req_mode  : funct3 (B/H/W/BU/HU)
//   req_addr   : byte address             req_wdata : store data (low byte/half for B/H)
//   rsp_valid  : response present         rsp_ready : requester takes response
//   rsp_rdata  : extended load data, 0 for stores/errors
//   rsp_err    : misaligned access or illegal mode
module dmem_responder #(
    parameter int WIDTH       = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_mode,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    // last counter value spent in WAIT; WAIT is never entered when LATENCY is 1
    localparam logic [3:0] CNT_END = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_rdata;
    logic             r_err;
    logic [WIDTH-1:0] r_mem [DEPTH_WORDS];

    logic [AW-1:0]    w_idx;
    logic [WIDTH-1:0] w_word;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [WIDTH-1:0] w_load;
    logic [WIDTH-1:0] w_wdata;
    logic [3:0]       w_be;
    logic             w_err;
    logic             w_acc;
    logic             w_unused;

    assign w_idx    = req_addr[AW+1:2];
    assign w_word   = r_mem[w_idx];
    assign w_byte   = w_word[{req_addr[1:0], 3'b000} +: 8];
    assign w_half   = w_word[{req_addr[1], 4'b0000} +: 16];
    // illegal modes 011/110/111, halves on odd addresses, words off word boundaries
    assign w_err    = (req_mode == 3'b011) || (req_mode[2:1] == 2'b11) ||
                      (req_mode[1:0] == 2'b01 && req_addr[0]) ||
                      (req_mode[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    // mode[2] selects zero extension; only legal modes reach the result
    assign w_load   = req_mode[1] ? w_word :
                      req_mode[0] ? {{(WIDTH-16){~req_mode[2] & w_half[15]}}, w_half} :
                                    {{(WIDTH-8){~req_mode[2] & w_byte[7]}}, w_byte};
    assign w_be     = req_mode[1] ? 4'b1111 :
                      req_mode[0] ? (req_addr[1] ? 4'b1100 : 4'b0011) :
                                    4'b0001 << req_addr[1:0];
    // replicate the narrow store data across lanes so the enables pick the right copy
    assign w_wdata  = req_mode[1] ? req_wdata :
                      req_mode[0] ? {2{req_wdata[15:0]}} : {4{req_wdata[7:0]}};
    assign w_acc    = req_valid && r_state == IDLE && rst;
    assign w_unused = &{1'b0, req_addr[WIDTH-1:AW+2]};

    assign req_ready = r_state == IDLE;
    assign rsp_valid = r_state == RESP;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    always_ff @(posedge clk)
        if (w_acc && req_we && !w_err)
            for (int i = 0; i < 4; i++)
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else
            case (r_state)
                IDLE: if (w_acc) begin
                    r_state <= (LATENCY == 1) ? RESP : WAIT;
                    r_cnt   <= 4'd0;
                    r_rdata <= (req_we || w_err) ? '0 : w_load;
                    r_err   <= w_err;
                end
                WAIT: if (r_cnt == CNT_END) r_state <= RESP;
                      else r_cnt <= r_cnt + 4'd1;
                RESP: if (rsp_ready) begin
                    r_state <= IDLE;
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector bench for dmem_responder (LATENCY 2, 1024 words).
module tb_dmem_responder;
    logic        clk = 0, rst = 1;
    logic        req_valid = 0, req_we = 0, rsp_ready = 1;
    logic [2:0]  req_mode = 3'b010;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    int n_cmp = 0, n_bad = 0;

    dmem_responder #(.WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;
    vec_t v[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // entered 1 time unit after an edge with req_ready high; rsp_ready is held high
    task automatic txn(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output logic e,
                       output int lat);
        req_valid = 1; req_we = we; req_mode = mode; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 0; lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rsp_rdata; e = rsp_err;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat;
        int          n;
        v.push_back('{1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0});
        v.push_back('{1'b0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0});
        v.push_back('{1'b1, 3'b010, 32'h20,   32'h80FF7F01, 32'h0,        1'b0});
        v.push_back('{1'b0, 3'b000, 32'h22,   32'h0,        32'hFFFFFFFF, 1'b0});
        v.push_back('{1'b0, 3'b100, 32'h22,   32'h0,        32'h000000FF, 1'b0});
        v.push_back('{1'b0, 3'b001, 32'h22,   32'h0,        32'hFFFF80FF, 1'b0});
        v.push_back('{1'b0, 3'b101, 32'h22,   32'h0,        32'h000080FF, 1'b0});
        v.push_back('{1'b0, 3'b000, 32'h20,   32'h0,        32'h00000001, 1'b0});
        v.push_back('{1'b0, 3'b000, 32'h21,   32'h0,        32'h0000007F, 1'b0});
        v.push_back('{1'b0, 3'b001, 32'h20,   32'h0,        32'h00007F01, 1'b0});
        v.push_back('{1'b0, 3'b000, 32'h23,   32'h0,        32'hFFFFFF80, 1'b0});
        v.push_back('{1'b1, 3'b010, 32'h30,   32'h11223344, 32'h0,        1'b0});
        v.push_back('{1'b1, 3'b000, 32'h31,   32'hFFFFFFAA, 32'h0,        1'b0});
        v.push_back('{1'b0, 3'b010, 32'h30,   32'h0,        32'h1122AA44, 1'b0});
        v.push_back('{1'b1, 3'b001, 32'h32,   32'h1234BEEF, 32'h0,        1'b0});
        v.push_back('{1'b0, 3'b010, 32'h30,   32'h0,        32'hBEEFAA44, 1'b0});
        v.push_back('{1'b1, 3'b010, 32'h40,   32'h55667788, 32'h0,        1'b0});
        v.push_back('{1'b0, 3'b010, 32'h41,   32'h0,        32'h0,        1'b1});
        v.push_back('{1'b1, 3'b001, 32'h43,   32'h0000FFFF, 32'h0,        1'b1});
        v.push_back('{1'b0, 3'b101, 32'h41,   32'h0,        32'h0,        1'b1});
        v.push_back('{1'b0, 3'b010, 32'h40,   32'h0,        32'h55667788, 1'b0});
        v.push_back('{1'b0, 3'b011, 32'h40,   32'h0,        32'h0,        1'b1});
        v.push_back('{1'b0, 3'b110, 32'h40,   32'h0,        32'h0,        1'b1});
        v.push_back('{1'b0, 3'b111, 32'h40,   32'h0,        32'h0,        1'b1});
        v.push_back('{1'b1, 3'b011, 32'h40,   32'h0,        32'h0,        1'b1});
        v.push_back('{1'b0, 3'b010, 32'h40,   32'h0,        32'h55667788, 1'b0});
        v.push_back('{1'b1, 3'b010, 32'h1008, 32'hCAFEF00D, 32'h0,        1'b0});
        v.push_back('{1'b0, 3'b010, 32'h8,    32'h0,        32'hCAFEF00D, 1'b0});

        #3 rst = 0;
        #1;
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_rdata", rsp_rdata, 32'd0);
        chk("rst rsp_err", 32'(rsp_err), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1;
        @(posedge clk); #1;
        chk("post-rst req_ready", 32'(req_ready), 32'd1);
        chk("post-rst rsp_valid", 32'(rsp_valid), 32'd0);

        foreach (v[i]) begin
            txn(v[i].we, v[i].mode, v[i].addr, v[i].wdata, rd, e, lat);
            chk($sformatf("v%0d rdata", i), rd, v[i].rdata);
            chk($sformatf("v%0d err", i), 32'(e), 32'(v[i].err));
            chk($sformatf("v%0d latency", i), 32'(lat), 32'd1);
            chk($sformatf("v%0d ready after", i), 32'(req_ready), 32'd1);
        end

        // back-pressure: response held while rsp_ready is low, new request refused
        rsp_ready = 0;
        req_valid = 1; req_we = 0; req_mode = 3'b010; req_addr = 32'h10;
        @(posedge clk); #1;
        req_valid = 0; n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp latency", 32'(n), 32'd1);
        req_valid = 1; req_we = 1; req_mode = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d rsp_valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d rsp_rdata", k), rsp_rdata, 32'hDEADBEEF);
            chk($sformatf("bp%0d rsp_err", k), 32'(rsp_err), 32'd0);
            chk($sformatf("bp%0d req_ready", k), 32'(req_ready), 32'd0);
        end
        req_valid = 0; rsp_ready = 1;
        @(posedge clk); #1;
        chk("bp release rsp_valid", 32'(rsp_valid), 32'd0);
        chk("bp release req_ready", 32'(req_ready), 32'd1);
        txn(1'b0, 3'b010, 32'h10, 32'h0, rd, e, lat);
        chk("bp store refused", rd, 32'hDEADBEEF);

        // reset during WAIT of a load
        req_valid = 1; req_we = 0; req_mode = 3'b010; req_addr = 32'h30;
        @(posedge clk); #1;
        req_valid = 0;
        chk("mid busy req_ready", 32'(req_ready), 32'd0);
        #2 rst = 0;
        #1;
        chk("mid rst req_ready", 32'(req_ready), 32'd1);
        chk("mid rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid rst rsp_rdata", rsp_rdata, 32'd0);
        chk("mid rst rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk); #2 rst = 1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("mid drop%0d rsp_valid", k), 32'(rsp_valid), 32'd0);
        end
        txn(1'b0, 3'b010, 32'h10, 32'h0, rd, e, lat);
        chk("kept after rst @10", rd, 32'hDEADBEEF);
        txn(1'b0, 3'b010, 32'h8, 32'h0, rd, e, lat);
        chk("kept after rst @8", rd, 32'hCAFEF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's data-memory port. It accepts one load or store request at a time over a valid/ready handshake and applies RISC-V byte, half and word access modes (funct3 encoding, same as `modeBU`). After a configurable wait-state latency it returns the response over a valid/ready handshake. It sits between the load/store path of the multi-cycle and pipelined cores and the word-organised data RAM, and replaces the zero-latency `data_memory` when stalls must be exercised.

## Interface
- `WIDTH`, 32, data and address width.
- `DEPTH_WORDS`, 1024, RAM depth in 32-bit words; power of two.
- `LATENCY`, 2, cycles from request acceptance to `rsp_valid`; range 1..15.
- `clk`  input  1  single clock, rising edge.
- `rst`  input  1  reset, asynchronous and active-low.
- `req_valid`  input  1  request present.
- `req_ready`  output  1  responder can accept a request.
- `req_we`  input  1  1 = store, 0 = load.
- `req_mode`  input  3  000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
- `req_addr`  input  WIDTH  byte address.
- `req_wdata`  input  WIDTH  store data; the low byte or half is used for B/H.
- `rsp_valid`  output  1  response present.
- `rsp_ready`  input  1  requester takes the response.
- `rsp_rdata`  output  WIDTH  load result, extended; 0 for stores and errors.
- `rsp_err`  output  1  misaligned access or illegal mode.

## Operation
- **States:**
  - IDLE: `req_ready` = 1.
  - WAIT: counts LATENCY-1 cycles, then goes to RESP.
  - RESP: `rsp_valid` = 1.
  - When LATENCY = 1, the FSM goes IDLE -> RESP directly.
- **Accept:**
  - A request is accepted when `req_valid` and `req_ready` are both high at a rising edge.
  - All request fields are captured at that edge.
  - Only one request is outstanding at a time.
- **Word index:** `req_addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS·4.
- **Alignment:**
  - H/HU requires `addr[0]` = 0.
  - W requires `addr[1:0]` = 0.
  - B/BU may use any address.
- **Modes 011, 110, 111** are illegal.
- **Error case:**
  - `rsp_err` = 1 and `rsp_rdata` = 0.
  - No RAM write occurs.
  - The normal latency is kept.
- **Store:**
  - Commits at the acceptance edge, using byte-lane enables from `addr[1:0]`.
  - Unselected bytes are unchanged.
  - A response is still issued, with `rsp_rdata` = 0.
- **Load:**
  - The RAM word is read at the acceptance edge.
  - The byte or half is selected by `addr[1:0]`.
  - B/H sign-extend; BU/HU zero-extend; W passes through unchanged.
- **Response:**
  - `rsp_valid`, `rsp_rdata` and `rsp_err` are held stable until `rsp_ready` = 1 at an edge.
  - The FSM then returns to IDLE.
- **RAM contents are not reset**; they are preserved across `rst`.

## Timing
- **Reset values:**
  - `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0.
  - FSM = IDLE, wait counter = 0.
- **Latency:**
  - A request accepted at edge T gives `rsp_valid` = 1 after edge T+LATENCY-1.
  - The response is therefore visible in cycle T+LATENCY.
- **Ready:**
  - `req_ready` is 0 from the cycle after acceptance until the cycle after the response handshake.
  - Back-to-back throughput is one request per LATENCY+1 cycles when `rsp_ready` is held at 1.
- **No combinational paths** from `req_*` to `rsp_*`, or from `rsp_ready` to `req_ready`. All outputs are registered or decoded from the state.
- **`rsp_ready` asserted early** (before `rsp_valid`) has no effect.
- **`req_valid` while `req_ready` = 0** is ignored. The requester must hold its request until it is accepted.
- **Reset mid-operation:**
  - The FSM returns to IDLE and any pending response is dropped.
  - A store accepted before reset stays committed.
- **Store then load to the same word** in consecutive transactions: the load returns the new data.

## Test plan
- **Reset behaviour:** Reset, then store W 0xDEADBEEF @0x10, then load W @0x10 with LATENCY = 2 and `rsp_ready` = 1. Expected: load `rsp_valid` appears 2 cycles after acceptance, `rsp_rdata` = 0xDEADBEEF, `rsp_err` = 0.
- **Sign/zero extension:** With word @0x20 = 0x80FF7F01:
  - load B @0x22 -> 0xFFFFFFFF
  - BU @0x22 -> 0x000000FF
  - H @0x22 -> 0xFFFF80FF
  - HU @0x22 -> 0x000080FF
  - B @0x20 -> 0x00000001
- **Byte-lane stores:**
  - Store B 0xAA @0x31 over word 0x11223344 -> reload W = 0x1122AA44.
  - Then store H 0xBEEF @0x32 -> 0xBEEFAA44.
- **Errors:**
  - Load W @0x41 -> `rsp_err` = 1, rdata = 0.
  - Store H @0x43 -> `rsp_err` = 1, and word @0x40 is unchanged.
  - Mode 011 -> `rsp_err` = 1.
- **Back-pressure:**
  - Hold `rsp_ready` = 0 for 5 cycles. Expected: `rsp_valid` and data stay stable, `req_ready` stays 0, and a second `req_valid` is not accepted.
  - Raise `rsp_ready`. Expected: IDLE next cycle.
- **Reset mid-operation and wrap:**
  - Assert `rst` low during WAIT of a load. Expected: all outputs return to their reset values immediately, with no response afterwards.
  - Store W @(DEPTH_WORDS·4 + 0x8), then load @0x8. Expected: the same data is returned.
